// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the CPU memory/IO bridge: IO register offsets
// (counted down from the top of the address space), STATUS bit positions,
// register-select enum, STATUS layout and FIFO pointer width helper.
package io_bridge_pkg;

    // Offsets below 2^ADDR_WIDTH of the four IO bytes
    localparam int unsigned OFF_TX_DATA = 4;
    localparam int unsigned OFF_STATUS  = 3;
    localparam int unsigned OFF_RX_DATA = 2;
    localparam int unsigned OFF_TICK    = 1;

    // STATUS bit indices
    localparam int unsigned ST_TX_FULL     = 0;
    localparam int unsigned ST_TX_EMPTY    = 1;
    localparam int unsigned ST_RX_VALID    = 2;
    localparam int unsigned ST_RX_OVERRUN  = 3;
    localparam int unsigned ST_TX_OVERFLOW = 4;

    typedef enum logic [2:0] {
        IO_NONE,
        IO_TX_DATA,
        IO_STATUS,
        IO_RX_DATA,
        IO_TICK
    } io_reg_e;

    typedef struct packed {
        logic [2:0] zero;
        logic       tx_overflow;
        logic       rx_overrun;
        logic       rx_valid;
        logic       tx_empty;
        logic       tx_full;
    } status_t;

    // Pointer width for a power-of-two FIFO depth
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// CPU memory port bundle.
//   master (cpu):    drives mem_raddr, mem_waddr, mem_data_in, mem_write
//   slave  (bridge): drives mem_data_out, mem_ready
interface mem_io_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [7:0]            mem_data_in;
    logic                  mem_write;
    logic [7:0]            mem_data_out;
    logic                  mem_ready;

    modport master (
        output mem_raddr, mem_waddr, mem_data_in, mem_write,
        input  mem_data_out, mem_ready
    );

    modport slave (
        input  mem_raddr, mem_waddr, mem_data_in, mem_write,
        output mem_data_out, mem_ready
    );
endinterface

// File: rtl/mem_io_bridge_byte_fifo.sv
// byte_fifo: power-of-two depth byte FIFO with show-ahead head output.
// Ports: clk, rst_n (async active-low), push_i/din_i, pop_i, dout_o (head),
//        full_o, empty_o, count_o (occupancy).
// A push while full is accepted only if a pop happens in the same cycle.
module byte_fifo
    import io_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [7:0]                 din_i,
    input  logic                       pop_i,
    output logic [7:0]                 dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [ptr_width(DEPTH):0]  count_o
);
    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_c, do_pop_c;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_pop_c  = pop_i & ~empty_o;
    assign do_push_c = push_i & (~full_o | do_pop_c);

    // Pointer/occupancy next state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: routes the cpu byte bus to block RAM and four IO bytes at the
// top of the address space (TX_DATA, STATUS, RX_DATA, TICK).
// Ports: clk, reset_n (async active-low); cpu (mem_io_bridge_if.slave);
//        ram_raddr/ram_waddr/ram_din/ram_we/ram_dout to the RAM;
//        tx_data/tx_valid/tx_ready to the UART TX; rx_data/rx_strobe from UART RX.
// Optional: IO_BRIDGE_TICK_EN enables the TICK counter (else TICK reads 0).
module mem_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned TICK_DIV   = 12000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_io_bridge_if.slave        cpu,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [7:0]            ram_din,
    output logic                  ram_we,
    input  logic [7:0]            ram_dout,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_strobe
);
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

    function automatic io_reg_e decode(input logic [ADDR_WIDTH-1:0] a);
        io_reg_e r;
        r = IO_NONE;
        if (a == ADDR_TOP - ADDR_WIDTH'(OFF_TX_DATA - 1)) r = IO_TX_DATA;
        if (a == ADDR_TOP - ADDR_WIDTH'(OFF_STATUS - 1))  r = IO_STATUS;
        if (a == ADDR_TOP - ADDR_WIDTH'(OFF_RX_DATA - 1)) r = IO_RX_DATA;
        if (a == ADDR_TOP - ADDR_WIDTH'(OFF_TICK - 1))    r = IO_TICK;
        return r;
    endfunction

    io_reg_e rd_sel_c, wr_sel_c;
    logic    tx_push_c, tx_pop_c, tx_full_c, tx_empty_c;
    logic    sts_wr_c, rx_rd_c, rx_clr_c, tick_wr_c;
    logic [7:0] tick_c;
    status_t status_c;
    logic [ptr_width(TX_DEPTH):0] tx_count_unused;

    logic       mem_ready_q;
    logic       io_sel_q,  io_sel_d;
    logic [7:0] io_byte_q, io_byte_d;
    logic       rx_rd_prev_q;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_overrun_q, rx_overrun_d;
    logic       tx_overflow_q, tx_overflow_d;

    assign rd_sel_c  = decode(cpu.mem_raddr);
    assign wr_sel_c  = decode(cpu.mem_waddr);

    // RAM side is a straight pass-through; IO writes never reach the RAM
    assign ram_raddr = cpu.mem_raddr;
    assign ram_waddr = cpu.mem_waddr;
    assign ram_din   = cpu.mem_data_in;
    assign ram_we    = reset_n & cpu.mem_write & (wr_sel_c == IO_NONE);

    assign tx_push_c = cpu.mem_write & (wr_sel_c == IO_TX_DATA);
    assign tx_pop_c  = tx_valid & tx_ready;
    assign tx_valid  = ~tx_empty_c;
    assign sts_wr_c  = cpu.mem_write & (wr_sel_c == IO_STATUS);
    assign tick_wr_c = cpu.mem_write & (wr_sel_c == IO_TICK);

    // RX clear fires only on the first cycle of a run of RX_DATA reads
    assign rx_rd_c   = (rd_sel_c == IO_RX_DATA);
    assign rx_clr_c  = rx_rd_c & ~rx_rd_prev_q;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (tx_push_c),
        .din_i   (cpu.mem_data_in),
        .pop_i   (tx_pop_c),
        .dout_o  (tx_data),
        .full_o  (tx_full_c),
        .empty_o (tx_empty_c),
        .count_o (tx_count_unused)
    );

    always_comb begin
        status_c             = '0;
        status_c.tx_full     = tx_full_c;
        status_c.tx_empty    = tx_empty_c;
        status_c.rx_valid    = rx_valid_q;
        status_c.rx_overrun  = rx_overrun_q;
        status_c.tx_overflow = tx_overflow_q;
    end

    // Sticky flags, W1C, and the RX holding register
    always_comb begin
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        rx_overrun_d  = rx_overrun_q;
        tx_overflow_d = tx_overflow_q;
        if (sts_wr_c && cpu.mem_data_in[ST_RX_OVERRUN])  rx_overrun_d  = 1'b0;
        if (sts_wr_c && cpu.mem_data_in[ST_TX_OVERFLOW]) tx_overflow_d = 1'b0;
        if (tx_push_c && tx_full_c && !tx_pop_c)         tx_overflow_d = 1'b1;
        if (rx_strobe) begin
            rx_data_d  = rx_data;
            rx_valid_d = 1'b1;
            if (rx_valid_q && !rx_clr_c) rx_overrun_d = 1'b1;
        end else if (rx_clr_c) begin
            rx_valid_d = 1'b0;
        end
    end

    // IO read byte captured alongside the RAM's own read cycle
    always_comb begin
        io_sel_d = (rd_sel_c != IO_NONE);
        case (rd_sel_c)
            IO_STATUS:  io_byte_d = status_c;
            IO_RX_DATA: io_byte_d = rx_data_q;
            IO_TICK:    io_byte_d = tick_c;
            default:    io_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready_q   <= 1'b0;
            io_sel_q      <= 1'b0;
            io_byte_q     <= 8'h00;
            rx_rd_prev_q  <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            mem_ready_q   <= 1'b1;
            io_sel_q      <= io_sel_d;
            io_byte_q     <= io_byte_d;
            rx_rd_prev_q  <= rx_rd_c;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    assign cpu.mem_ready    = mem_ready_q;
    assign cpu.mem_data_out = mem_ready_q ? (io_sel_q ? io_byte_q : ram_dout) : 8'h00;

`ifdef IO_BRIDGE_TICK_EN
    logic [31:0] presc_q, presc_d;
    logic [7:0]  tick_q, tick_d;

    // Prescaler divides clk by TICK_DIV; any TICK write restarts both stages
    always_comb begin
        presc_d = presc_q + 32'd1;
        tick_d  = tick_q;
        if (tick_wr_c) begin
            presc_d = '0;
            tick_d  = '0;
        end else if (presc_q == 32'(TICK_DIV - 1)) begin
            presc_d = '0;
            tick_d  = tick_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_c = tick_q;
`else
    logic tick_unused;
    assign tick_c      = 8'h00;
    assign tick_unused = tick_wr_c | (TICK_DIV == 0);
`endif
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: vector table for RAM/IO decode plus scripted
// sequences for TX FIFO, RX register, simultaneous events, reset and TICK.
module tb_mem_io_bridge;
    localparam int unsigned AW = 9;
    localparam logic [AW-1:0] A_TX = 9'd508;
    localparam logic [AW-1:0] A_ST = 9'd509;
    localparam logic [AW-1:0] A_RX = 9'd510;
    localparam logic [AW-1:0] A_TK = 9'd511;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [7:0]    ram_din, ram_dout, tx_data, rx_data;
    logic          ram_we, tx_valid, tx_ready, rx_strobe;

    always #5 clk = ~clk;

    mem_io_bridge_if #(.ADDR_WIDTH(AW)) cpu_if ();

    mem_io_bridge #(.ADDR_WIDTH(AW), .TX_DEPTH(8), .TICK_DIV(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu       (cpu_if),
        .ram_raddr (ram_raddr),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

    // Behavioural block RAM, 1-cycle synchronous read
    logic [7:0] ram [512];
    always @(posedge clk) begin
        if (ram_we) ram[ram_waddr] <= ram_din;
        ram_dout <= ram[ram_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [7:0]    wdata;
        logic [AW-1:0] raddr;
        logic          chk;
        logic [7:0]    exp;
        logic          exp_we;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    // Advance one clock and retire the read issued in the previous cycle
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        while (exp_q.size() > 0) chk(name_q.pop_front(), cpu_if.mem_data_out, exp_q.pop_front());
    endtask

    task automatic bus(input logic we, input logic [AW-1:0] wa, input logic [7:0] wd, input logic [AW-1:0] ra);
        cpu_if.mem_write   = we;
        cpu_if.mem_waddr   = wa;
        cpu_if.mem_data_in = wd;
        cpu_if.mem_raddr   = ra;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [7:0] e, input string n);
        bus(1'b0, '0, 8'h00, a);
        exp_q.push_back(e);
        name_q.push_back(n);
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        bus(1'b1, a, d, '0);
        step();
        bus(1'b0, '0, 8'h00, '0);
    endtask

    task automatic rx(input logic [7:0] d);
        rx_strobe = 1'b1;
        rx_data   = d;
        step();
        rx_strobe = 1'b0;
    endtask

    task automatic drain(input logic [7:0] first, input int n, input logic [7:0] last, input string tag);
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [7:0] e;
            e = (i == n - 1) ? last : first + 8'(i);
            #1 chk($sformatf("%s_tx_data%0d", tag, i), tx_data, e);
            chk($sformatf("%s_tx_valid%0d", tag, i), 8'(tx_valid), 8'h01);
            step();
        end
        tx_ready = 1'b0;
        #1 chk($sformatf("%s_tx_valid_end", tag), 8'(tx_valid), 8'h00);
    endtask

    initial begin
        vecs[0] = '{1'b1, 9'h010, 8'h5A, 9'h000, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b1, 9'd507, 8'hC3, 9'h010, 1'b1, 8'h5A, 1'b1};
        vecs[2] = '{1'b0, 9'h000, 8'h00, 9'd507, 1'b1, 8'hC3, 1'b0};
        vecs[3] = '{1'b1, A_RX,   8'hFF, A_TX,   1'b1, 8'h00, 1'b0};
        vecs[4] = '{1'b1, A_TK,   8'h55, A_ST,   1'b1, 8'h02, 1'b0};
        vecs[5] = '{1'b0, 9'h000, 8'h00, A_TK,   1'b1, 8'h00, 1'b0};
        vecs[6] = '{1'b1, 9'h0FF, 8'h77, A_RX,   1'b1, 8'h00, 1'b1};
        vecs[7] = '{1'b0, 9'h000, 8'h00, 9'h0FF, 1'b1, 8'h77, 1'b0};
        vecs[8] = '{1'b0, 9'h000, 8'h00, 9'h010, 1'b1, 8'h5A, 1'b0};

        bus(1'b0, '0, 8'h00, '0);
        tx_ready = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00;
        #12;
        chk("rst_ready", 8'(cpu_if.mem_ready), 8'h00);
        chk("rst_tx_valid", 8'(tx_valid), 8'h00);
        chk("rst_data_out", cpu_if.mem_data_out, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("ready_after_rst", 8'(cpu_if.mem_ready), 8'h01);

        // Decode / RAM / IO read-back table
        for (int i = 0; i < 9; i++) begin
            bus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
            #1 chk($sformatf("vec%0d_ram_we", i), 8'(ram_we), 8'(vecs[i].exp_we));
            if (vecs[i].chk) begin
                exp_q.push_back(vecs[i].exp);
                name_q.push_back($sformatf("vec%0d_rdata", i));
            end
            step();
        end
        bus(1'b0, '0, 8'h00, '0);

        // TX fill, overflow, ordered drain, W1C
        for (int i = 0; i < 9; i++) wr(A_TX, 8'h41 + 8'(i));
        rd(A_ST, 8'h11, "tx_status_full_ovf");
        drain(8'h41, 8, 8'h48, "tx");
        rd(A_ST, 8'h12, "tx_status_empty_ovf");
        wr(A_ST, 8'h10);
        rd(A_ST, 8'h02, "tx_status_w1c");

        // RX basic, held read clears once, overrun
        rx(8'h33);
        rd(A_ST, 8'h06, "rx_status_valid");
        rd(A_RX, 8'h33, "rx_hold0");
        rd(A_RX, 8'h33, "rx_hold1");
        rd(A_RX, 8'h33, "rx_hold2");
        rd(A_ST, 8'h02, "rx_status_cleared");
        bus(1'b0, '0, 8'h00, A_RX);
        rx(8'h44);
        rd(A_ST, 8'h06, "rx_held_no_reclear");
        rd(A_RX, 8'h44, "rx_second");
        bus(1'b0, '0, 8'h00, '0);
        rx(8'h01);
        rx(8'h02);
        rd(A_RX, 8'h02, "rx_overwrite");
        rd(A_ST, 8'h0A, "rx_status_overrun");
        wr(A_ST, 8'h08);
        rd(A_ST, 8'h02, "rx_status_w1c");

        // Full FIFO with push+pop in the same cycle
        for (int i = 0; i < 8; i++) wr(A_TX, 8'h61 + 8'(i));
        tx_ready = 1'b1;
        bus(1'b1, A_TX, 8'h77, '0);
        #1 chk("sim_pop_head", tx_data, 8'h61);
        step();
        tx_ready = 1'b0;
        bus(1'b0, '0, 8'h00, '0);
        rd(A_ST, 8'h01, "sim_status_full_no_ovf");
        drain(8'h62, 8, 8'h77, "sim");

        // RX strobe coinciding with the clearing read
        bus(1'b0, '0, 8'h00, '0);
        rx(8'h10);
        rx_strobe = 1'b1; rx_data = 8'h20;
        rd(A_RX, 8'h10, "sim_rx_old");
        rx_strobe = 1'b0;
        rd(A_ST, 8'h06, "sim_rx_status");
        rd(A_RX, 8'h20, "sim_rx_new");
        rd(A_ST, 8'h02, "sim_rx_cleared");

        // Reset asserted with bytes queued and a pop in flight
        bus(1'b0, '0, 8'h00, '0);
        for (int i = 0; i < 3; i++) wr(A_TX, 8'h91 + 8'(i));
        tx_ready = 1'b1;
        step();
        bus(1'b1, 9'h020, 8'hEE, A_ST);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_tx_valid", 8'(tx_valid), 8'h00);
        chk("mid_rst_ready", 8'(cpu_if.mem_ready), 8'h00);
        chk("mid_rst_data_out", cpu_if.mem_data_out, 8'h00);
        chk("mid_rst_ram_we", 8'(ram_we), 8'h00);
        tx_ready = 1'b0;
        bus(1'b0, '0, 8'h00, '0);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("post_rst_tx_valid", 8'(tx_valid), 8'h00);
        step();
        chk("post_rst_ready", 8'(cpu_if.mem_ready), 8'h01);
        rd(A_ST, 8'h02, "post_rst_status");

`ifdef IO_BRIDGE_TICK_EN
        wr(A_TK, 8'h00);
        for (int i = 0; i < 40; i++) step();
        rd(A_TK, 8'd10, "tick_count10");
        wr(A_TK, 8'h00);
        for (int i = 0; i < 1024; i++) step();
        rd(A_TK, 8'h00, "tick_wrapped");
        wr(A_TK, 8'h00);
        rd(A_TK, 8'h00, "tick_after_write");
`else
        for (int i = 0; i < 40; i++) step();
        rd(A_TK, 8'h00, "tick_disabled");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
